dcm_lock_supervisor: RTL



---
 rtl/dcm_lock_supervisor_if.sv | 50 +++++
 rtl/dcm_lock_supervisor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor_if.sv
// -----------------------------------------------------------------------------
// dcm_lock_supervisor_if
//
// Groups the control/status signals of the DCM lock supervisor. The clock and
// asynchronous reset stay plain ports on the supervisor itself.
//
//   enable_i       level enable; 0 parks the supervisor in IDLE
//   locked_i       asynchronous qualified lock flag from the clock stage
//   timeout_i      lock-wait timeout in clock cycles, 0 = wait forever
//   max_retries_i  extra reset attempts allowed after the first
//   force_reset_i  single-cycle pulse, restart the reset sequence
//   clear_count_i  single-cycle pulse, clear the loss counter
//   dcm_reset_o    registered reset to the DCM
//   locked_o       high only in LOCKED
//   fail_o         high only in FAILED
//   loss_count_o   saturating lock-loss event count
//   retry_count_o  retries consumed in the current sequence
//   state_o        IDLE=0 RESET=1 WAIT=2 LOCKED=3 FAILED=4
//
// slave  : supervisor side
// master : register interface / controller side
// -----------------------------------------------------------------------------
interface dcm_lock_supervisor_if;
    logic        enable_i;
    logic        locked_i;
    logic [15:0] timeout_i;
    logic [3:0]  max_retries_i;
    logic        force_reset_i;
    logic        clear_count_i;
    logic        dcm_reset_o;
    logic        locked_o;
    logic        fail_o;
    logic [7:0]  loss_count_o;
    logic [3:0]  retry_count_o;
    logic [2:0]  state_o;

    modport slave (
        input  enable_i, locked_i, timeout_i, max_retries_i,
               force_reset_i, clear_count_i,
        output dcm_reset_o, locked_o, fail_o, loss_count_o,
               retry_count_o, state_o
    );

    modport master (
        output enable_i, locked_i, timeout_i, max_retries_i,
               force_reset_i, clear_count_i,
        input  dcm_reset_o, locked_o, fail_o, loss_count_o,
               retry_count_o, state_o
    );
endinterface

// File: rtl/dcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// dcm_lock_supervisor
//
// Supervises a DCM lock flag: issues timed reset pulses, waits for a filtered
// lock with a programmable timeout, retries up to a programmable limit, then
// flags a hard failure. While locked it debounces lock loss, counts loss
// events and restarts the reset sequence.
//
// Ports:
//   clk_i      supervisor clock, free-running, independent of the DCM
//   reset_n_i  asynchronous active-low reset
//   sup        dcm_lock_supervisor_if.slave (control inputs, status outputs)
//
// Parameters:
//   RESET_CYCLES  cycles dcm_reset_o is held per attempt (>= 1)
//   LOCK_FILTER   consecutive samples needed to accept a lock change (>= 1)
// -----------------------------------------------------------------------------
module dcm_lock_supervisor #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_FILTER  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    dcm_lock_supervisor_if.slave   sup
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int LF_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCK_FILTER - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAILED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        retry_q, retry_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [7:0]        loss_q;
    logic              loss_evt;
    logic              timed_out;
    logic              dcm_reset_q, locked_q, fail_q;

    logic              sync_p0, sync_p1;
    logic              lk_acc;
    logic [LF_W-1:0]   filt_cnt;

    // Synchronizer and lock filter. Both are held cleared while the DCM is
    // idle or in reset, so every WAIT starts from "not locked" and a lock
    // must be seen fresh through the full synchronizer + filter path.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            lk_acc   <= 1'b0;
            filt_cnt <= '0;
        end else if (state_q == ST_IDLE || state_q == ST_RESET) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            lk_acc   <= 1'b0;
            filt_cnt <= '0;
        end else begin
            sync_p0 <= sup.locked_i;
            sync_p1 <= sync_p0;
            if (sync_p1 == lk_acc) begin
                filt_cnt <= '0;
            end else if (filt_cnt == LF_LAST) begin
                lk_acc   <= sync_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // to_cnt_q holds the number of WAIT cycles already completed.
    assign timed_out = ({1'b0, to_cnt_q} + 17'd1) >= {1'b0, sup.timeout_i};

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        loss_evt  = 1'b0;
        if (!sup.enable_i) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else if (sup.force_reset_i && state_q != ST_IDLE) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    retry_d = '0;
                end
                ST_RESET: begin
                    if (rst_cnt_q == RC_LAST) begin
                        state_d = ST_WAIT;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lk_acc) begin
                        state_d = ST_LOCKED;
                        retry_d = '0;
                    end else if (sup.timeout_i != 16'd0 && timed_out) begin
                        if (retry_q >= sup.max_retries_i) begin
                            state_d = ST_FAILED;
                        end else begin
                            state_d = ST_RESET;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        // saturate rather than wrap during an endless wait
                        to_cnt_d = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!lk_acc) begin
                        loss_evt = 1'b1;
                        state_d  = ST_RESET;
                        retry_d  = '0;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with
    // state_q in the cycle after each transition.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            retry_q     <= '0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            loss_q      <= '0;
            dcm_reset_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            dcm_reset_q <= (state_d == ST_RESET);
            locked_q    <= (state_d == ST_LOCKED);
            fail_q      <= (state_d == ST_FAILED);
            // a clear coinciding with a loss still records that loss
            if (sup.clear_count_i) begin
                loss_q <= {7'd0, loss_evt};
            end else if (loss_evt && loss_q != 8'hFF) begin
                loss_q <= loss_q + 8'd1;
            end
        end
    end

    assign sup.dcm_reset_o   = dcm_reset_q;
    assign sup.locked_o      = locked_q;
    assign sup.fail_o        = fail_q;
    assign sup.loss_count_o  = loss_q;
    assign sup.retry_count_o = retry_q;
    assign sup.state_o       = state_q;

endmodule
